force_frame_ctrl: RTL and testbench
===================================

# force_frame_ctrl

Frame sequencer and write-port arbiter for the 16-bit force output buffer. Shares the buffer's single random-write port between NREQ compute lanes with round-robin arbitration. Tracks which particle indices have been written in the current frame and opens the buffer's stream side only once all N forces are present. Closes the frame after the buffer reports DONE. Sits between the compute lanes and the output buffer; drives its CLEAR, FRAME_VALID, WR_EN, WR_IDX, FORCE_X and FORCE_Y.

## Interface
- N, 256, particles per frame (≥2)
- IDX_BITS, $clog2(N), particle index width
- NREQ, 2, number of compute-lane requesters (≥1)

Ports:
- CLK_IN  in  1  single clock, rising edge
- RESET_IN  in  1  asynchronous, active-low reset
- START  in  1  begin a frame; sampled only in IDLE
- ABORT  in  1  synchronous abort, from any state back to IDLE
- REQ_VALID  in  NREQ  lane i holds a force write
- REQ_IDX  in  NREQ*IDX_BITS  lane i particle index, slice [i*IDX_BITS +: IDX_BITS]
- REQ_FX, REQ_FY  in  NREQ*16  lane i force components, slice [i*16 +: 16]
- REQ_READY  out  NREQ  one-hot grant; lane i's write is accepted when REQ_VALID[i] && REQ_READY[i]
- WR_EN, WR_IDX (IDX_BITS), FORCE_X, FORCE_Y (16)  out  to buffer write port; registered
- CLEAR  out  1  to buffer
- FRAME_VALID  out  1  to buffer
- BUF_DONE  in  1  buffer DONE level
- BUSY  out  1  state ≠ IDLE
- FRAME_DONE  out  1  one-cycle pulse at frame end
- DUP_ERR  out  1  sticky; a duplicate or out-of-range index was seen this frame

## Operation
- States: IDLE, CLR, FILL, DRAIN, STREAM, FIN.
- IDLE: START=1 → CLR.
- CLR (1 cycle): CLEAR=1. Clear the N-bit written bitmap, the write counter (IDX_BITS+1 bits), DUP_ERR and the RR pointer. Next state FILL.
- FILL: grant at most one lane per cycle.
  - Round-robin: search from pointer p upward, mod NREQ. Grant the first lane with REQ_VALID=1. After a grant to lane i, set p = (i+1) mod NREQ.
  - REQ_READY is combinational from REQ_VALID, p and state. It is zero outside FILL.
  - Accepted index not yet written and < N: set its bitmap bit, increment the counter, register WR_EN=1 with the lane's idx/FX/FY.
  - Accepted index already written, or ≥ N: still accept (READY=1, request consumed), suppress WR_EN, set DUP_ERR.
  - On the cycle the counter reaches N: → DRAIN. Further requests are not granted.
- DRAIN (1 cycle): the last registered write lands in the buffer. → STREAM.
- STREAM: FRAME_VALID=1. Stay until BUF_DONE=1, then → FIN.
- FIN (1 cycle): FRAME_DONE=1, FRAME_VALID=0. → IDLE.
- ABORT=1 in any state → IDLE next cycle. FRAME_DONE is not pulsed. DUP_ERR holds its value.
- ABORT has priority over START, grants and BUF_DONE in the same cycle. No grant is issued in an ABORT cycle.
- START outside IDLE is ignored.
- CLEAR, FRAME_VALID, FRAME_DONE and BUSY are decoded from the state register only.

## Timing
- Reset (async, RESET_IN=0): state IDLE, p=0, counter=0, bitmap=0.
  - All outputs 0: REQ_READY, WR_EN, WR_IDX, FORCE_X, FORCE_Y, CLEAR, FRAME_VALID, BUSY, FRAME_DONE, DUP_ERR.
  - Reset mid-frame abandons the frame immediately.
- START high at edge t → CLEAR=1 in cycle t+1 → FILL from t+2; REQ_READY can assert in t+2.
- Grant in cycle g → WR_EN/WR_IDX/FORCE_* valid in cycle g+1 only. WR_EN is high for exactly one cycle per unique write.
- The N-th unique grant at g → DRAIN at g+1, with the last WR_EN also at g+1 → FRAME_VALID=1 from g+2.
- Minimum FILL length: N cycles.
- BUF_DONE seen at edge s → FIN at s+1 (FRAME_DONE=1, FRAME_VALID=0) → IDLE at s+2. START is accepted again from s+2.
- Back-to-back frames: START held high across FIN causes CLR at s+3.

## Test plan
- Reset mid-FILL (N=4, NREQ=2): assert RESET_IN=0 asynchronously between edges → all outputs 0 immediately; after release, START gives a clean frame.
- Single lane (N=4, NREQ=2): lane0 writes idx 3,2,1,0 with FX=0x0011·idx → 4 WR_EN pulses each one cycle after its grant; FRAME_VALID rises 2 cycles after the 4th grant; drive BUF_DONE → FRAME_DONE pulse, BUSY=0 the next cycle.
- Round-robin (N=4): both lanes valid continuously, lane0 idx 0,1 and lane1 idx 2,3 → grant order L0,L1,L0,L1; WR_IDX sequence 0,2,1,3.
- Duplicate (N=4): lane0 writes idx 1,1,0,2,3 → the second idx-1 write has READY=1, no WR_EN, DUP_ERR=1; frame still completes after 5 grants; DUP_ERR clears in the next CLR.
- ABORT in STREAM: FRAME_VALID drops the next cycle, no FRAME_DONE pulse; a START in the same cycle as the ABORT is ignored.
- Out-of-order completion (N=4): last write is idx 0 → buffer idx 0 holds the new value on the first FRAME_VALID cycle.

Source files
------------

// File: rtl/force_frame_ctrl.sv
// -----------------------------------------------------------------------------
// force_frame_ctrl
//
// Frame sequencer and write-port arbiter for the 16-bit force output buffer.
// NREQ compute lanes share the buffer's single random-write port through a
// round-robin arbiter. A written-index bitmap and a unique-write counter track
// frame completion; the buffer's stream side is opened only once all N forces
// have landed, and the frame is closed after the buffer reports DONE.
//
// Ports
//   CLK_IN       in   1              clock, rising edge
//   RESET_IN     in   1              asynchronous active-low reset
//   START        in   1              begin a frame (sampled in IDLE only)
//   ABORT        in   1              synchronous abort back to IDLE
//   REQ_VALID    in   NREQ           lane i holds a force write
//   REQ_IDX      in   NREQ*IDX_BITS  lane i index, [i*IDX_BITS +: IDX_BITS]
//   REQ_FX/FY    in   NREQ*16        lane i force components, [i*16 +: 16]
//   REQ_READY    out  NREQ           one-hot grant (combinational)
//   WR_EN        out  1              registered buffer write strobe
//   WR_IDX       out  IDX_BITS       registered buffer write index
//   FORCE_X/Y    out  16             registered buffer write data
//   CLEAR        out  1              buffer clear (CLR state)
//   FRAME_VALID  out  1              buffer stream enable (STREAM state)
//   BUF_DONE     in   1              buffer DONE level
//   BUSY         out  1              controller not idle
//   FRAME_DONE   out  1              one-cycle frame-end pulse (FIN state)
//   DUP_ERR      out  1              sticky duplicate / out-of-range index flag
// -----------------------------------------------------------------------------
module force_frame_ctrl #(
    parameter int N        = 256,
    parameter int IDX_BITS = $clog2(N),
    parameter int NREQ     = 2
) (
    input  logic                     CLK_IN,
    input  logic                     RESET_IN,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [NREQ-1:0]          REQ_VALID,
    input  logic [NREQ*IDX_BITS-1:0] REQ_IDX,
    input  logic [NREQ*16-1:0]       REQ_FX,
    input  logic [NREQ*16-1:0]       REQ_FY,
    output logic [NREQ-1:0]          REQ_READY,
    output logic                     WR_EN,
    output logic [IDX_BITS-1:0]      WR_IDX,
    output logic [15:0]              FORCE_X,
    output logic [15:0]              FORCE_Y,
    output logic                     CLEAR,
    output logic                     FRAME_VALID,
    input  logic                     BUF_DONE,
    output logic                     BUSY,
    output logic                     FRAME_DONE,
    output logic                     DUP_ERR
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = IDX_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILL,
        S_DRAIN,
        S_STREAM,
        S_FIN
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [PTR_W-1:0]     ptr_q;       // round-robin search start
    logic [CNT_W-1:0]     cnt_q;       // unique writes this frame
    logic [N-1:0]         bitmap_q;    // indices written this frame

    logic [NREQ-1:0]      grant;
    logic                 gnt_any;
    logic [PTR_W-1:0]     gnt_lane;
    logic [PTR_W-1:0]     cand;

    logic [IDX_BITS-1:0]  sel_idx;
    logic [15:0]          sel_fx;
    logic [15:0]          sel_fy;
    logic                 in_range;
    logic                 accept_new;
    logic                 accept_dup;
    logic                 last_write;

    // -------------------------------------------------------------------------
    // Round-robin arbiter. Searches upward from ptr_q, wrapping mod NREQ, and
    // grants the first valid lane. Only active in FILL, and never while ABORT
    // is high so an aborted cycle cannot consume a request.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch is inferred.
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_lane = '0;
        cand     = '0;
        if (state_q == S_FILL && !ABORT) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = PTR_W'((int'(ptr_q) + k) % NREQ);
                if (!gnt_any && REQ_VALID[cand]) begin
                    gnt_any  = 1'b1;
                    gnt_lane = cand;
                end
            end
            if (gnt_any) begin
                grant[gnt_lane] = 1'b1;
            end
        end
    end

    assign REQ_READY = grant;

    // Data of the granted lane.
    assign sel_idx = REQ_IDX[int'(gnt_lane)*IDX_BITS +: IDX_BITS];
    assign sel_fx  = REQ_FX[int'(gnt_lane)*16 +: 16];
    assign sel_fy  = REQ_FY[int'(gnt_lane)*16 +: 16];

    // A granted request is always consumed; it only produces a buffer write
    // when its index is in range and not yet written this frame.
    assign in_range   = (int'(sel_idx) < N);
    assign accept_new = gnt_any && in_range && !bitmap_q[sel_idx];
    assign accept_dup = gnt_any && !accept_new;
    assign last_write = accept_new && (cnt_q == CNT_W'(N - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample pre-edge values regardless of statement order.
        if (!RESET_IN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. ABORT overrides everything, including START, BUF_DONE
    // and the FILL completion.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (START)      state_d = S_CLR;
                S_CLR:                    state_d = S_FILL;
                S_FILL:   if (last_write) state_d = S_DRAIN;
                S_DRAIN:                  state_d = S_STREAM;
                S_STREAM: if (BUF_DONE)   state_d = S_FIN;
                S_FIN:                    state_d = S_IDLE;
                default:                  state_d = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame bookkeeping and registered write port.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        // NOTE: the bitmap is a flop vector, not a RAM, so it takes the
        // asynchronous reset like any other register.
        if (!RESET_IN) begin
            ptr_q    <= '0;
            cnt_q    <= '0;
            bitmap_q <= '0;
            WR_EN    <= 1'b0;
            WR_IDX   <= '0;
            FORCE_X  <= '0;
            FORCE_Y  <= '0;
            DUP_ERR  <= 1'b0;
        end else begin
            WR_EN <= 1'b0;

            if (state_q == S_CLR && !ABORT) begin
                ptr_q    <= '0;
                cnt_q    <= '0;
                bitmap_q <= '0;
                DUP_ERR  <= 1'b0;
            end

            if (gnt_any) begin
                ptr_q <= (int'(gnt_lane) == NREQ - 1) ? '0 : gnt_lane + 1'b1;
            end

            if (accept_new) begin
                bitmap_q[sel_idx] <= 1'b1;
                cnt_q             <= cnt_q + 1'b1;
                WR_EN             <= 1'b1;
                WR_IDX            <= sel_idx;
                FORCE_X           <= sel_fx;
                FORCE_Y           <= sel_fy;
            end

            if (accept_dup) begin
                DUP_ERR <= 1'b1;
            end
        end
    end

    // Status outputs decoded purely from the state register.
    assign CLEAR       = (state_q == S_CLR);
    assign FRAME_VALID = (state_q == S_STREAM);
    assign FRAME_DONE  = (state_q == S_FIN);
    assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_force_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_force_frame_ctrl
//
// Self-checking bench for force_frame_ctrl (N=4, NREQ=2). A phase-level
// reference model predicts every output each cycle; lanes are fed from
// per-lane request queues; a small buffer image records landed writes.
// -----------------------------------------------------------------------------
module tb_force_frame_ctrl;

    localparam int N  = 4;
    localparam int IB = 2;
    localparam int NR = 2;

    localparam int P_IDLE   = 0;
    localparam int P_CLR    = 1;
    localparam int P_FILL   = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_STREAM = 4;
    localparam int P_FIN    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [NR-1:0]     req_valid;
    logic [NR*IB-1:0]  req_idx;
    logic [NR*16-1:0]  req_fx;
    logic [NR*16-1:0]  req_fy;
    logic [NR-1:0]     req_ready;
    logic              wr_en;
    logic [IB-1:0]     wr_idx;
    logic [15:0]       force_x;
    logic [15:0]       force_y;
    logic              clear;
    logic              frame_valid;
    logic              buf_done;
    logic              busy;
    logic              frame_done;
    logic              dup_err;

    force_frame_ctrl #(.N(N), .IDX_BITS(IB), .NREQ(NR)) dut (
        .CLK_IN      (clk),
        .RESET_IN    (rst_n),
        .START       (start),
        .ABORT       (abort),
        .REQ_VALID   (req_valid),
        .REQ_IDX     (req_idx),
        .REQ_FX      (req_fx),
        .REQ_FY      (req_fy),
        .REQ_READY   (req_ready),
        .WR_EN       (wr_en),
        .WR_IDX      (wr_idx),
        .FORCE_X     (force_x),
        .FORCE_Y     (force_y),
        .CLEAR       (clear),
        .FRAME_VALID (frame_valid),
        .BUF_DONE    (buf_done),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done),
        .DUP_ERR     (dup_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IB-1:0] idx;
        logic [15:0]   fx;
        logic [15:0]   fy;
    } wr_t;

    wr_t lq0[$];
    wr_t lq1[$];
    bit  rand_valid;

    // Reference model
    int            m_phase;
    int            m_ptr;
    int            m_count;
    int            m_gnt;
    bit            m_written[N];
    bit            m_dup;
    bit            m_wr_en;
    logic [IB-1:0] m_wr_idx;
    logic [15:0]   m_fx;
    logic [15:0]   m_fy;

    logic [15:0]   tb_buf[N];
    int            wr_seen[$];
    int            obs_grants;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t mk(input int idx, input int fx, input int fy);
        wr_t w;
        w.idx = IB'(idx);
        w.fx  = 16'(fx);
        w.fy  = 16'(fy);
        return w;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_ptr   = 0;
        m_count = 0;
        m_gnt   = -1;
        m_dup   = 1'b0;
        m_wr_en = 1'b0;
        foreach (m_written[i]) m_written[i] = 1'b0;
    endtask

    task automatic drive_lanes();
        req_valid = '0;
        if (lq0.size() > 0) begin
            req_valid[0]  = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
            req_idx[1:0]  = lq0[0].idx;
            req_fx[15:0]  = lq0[0].fx;
            req_fy[15:0]  = lq0[0].fy;
        end
        if (lq1.size() > 0) begin
            req_valid[1]  = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
            req_idx[3:2]  = lq1[0].idx;
            req_fx[31:16] = lq1[0].fx;
            req_fy[31:16] = lq1[0].fy;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},       req_ready,   0);
        check({tag, "_wr_en"},       wr_en,       0);
        check({tag, "_wr_idx"},      wr_idx,      0);
        check({tag, "_force_x"},     force_x,     0);
        check({tag, "_force_y"},     force_y,     0);
        check({tag, "_clear"},       clear,       0);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_frame_done"},  frame_done,  0);
        check({tag, "_dup_err"},     dup_err,     0);
    endtask

    // One clock cycle: compare outputs with the model at the falling edge,
    // advance the model, then after the rising edge update the lane inputs.
    task automatic cycle();
        logic [NR-1:0] er;
        logic [IB-1:0] idx;
        int            g;
        @(negedge clk);
        g  = -1;
        er = '0;
        if (m_phase == P_FILL && !abort) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        if (g >= 0) er[g] = 1'b1;

        check("req_ready",   req_ready,   er);
        check("wr_en",       wr_en,       m_wr_en);
        if (m_wr_en) begin
            check("wr_idx",  wr_idx,  m_wr_idx);
            check("force_x", force_x, m_fx);
            check("force_y", force_y, m_fy);
        end
        check("clear",       clear,       m_phase == P_CLR);
        check("frame_valid", frame_valid, m_phase == P_STREAM);
        check("busy",        busy,        m_phase != P_IDLE);
        check("frame_done",  frame_done,  m_phase == P_FIN);
        check("dup_err",     dup_err,     m_dup);

        // Buffer image and observation logs fed from the DUT's outputs.
        if (clear) foreach (tb_buf[i]) tb_buf[i] = '0;
        if (wr_en) begin
            tb_buf[wr_idx] = force_x;
            wr_seen.push_back(int'(wr_idx));
        end
        if ((req_ready & req_valid) != '0) obs_grants++;

        m_wr_en = 1'b0;
        if (abort) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (start) m_phase = P_CLR;
                P_CLR: begin
                    foreach (m_written[i]) m_written[i] = 1'b0;
                    m_count = 0;
                    m_dup   = 1'b0;
                    m_ptr   = 0;
                    m_phase = P_FILL;
                end
                P_FILL: if (g >= 0) begin
                    idx   = req_idx[g*IB +: IB];
                    m_ptr = (g + 1) % NR;
                    if (int'(idx) < N && !m_written[idx]) begin
                        m_written[idx] = 1'b1;
                        m_count++;
                        m_wr_en  = 1'b1;
                        m_wr_idx = idx;
                        m_fx     = req_fx[g*16 +: 16];
                        m_fy     = req_fy[g*16 +: 16];
                        if (m_count == N) m_phase = P_DRAIN;
                    end else begin
                        m_dup = 1'b1;
                    end
                end
                P_DRAIN:  m_phase = P_STREAM;
                P_STREAM: if (buf_done) m_phase = P_FIN;
                P_FIN:    m_phase = P_IDLE;
                default:  m_phase = P_IDLE;
            endcase
        end
        m_gnt = g;

        @(posedge clk);
        #1;
        if (m_gnt == 0 && lq0.size() > 0) void'(lq0.pop_front());
        if (m_gnt == 1 && lq1.size() > 0) void'(lq1.pop_front());
        drive_lanes();
    endtask

    task automatic wait_phase(input int target, input int budget);
        int n;
        n = 0;
        while (m_phase != target && n < budget) begin
            cycle();
            n++;
        end
        if (m_phase != target) check("wait_phase_timeout", m_phase, target);
    endtask

    task automatic start_frame();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_frame();
        buf_done = 1'b1;
        cycle();
        buf_done = 1'b0;
        wait_phase(P_IDLE, 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[4];
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; buf_done = 1'b0;
        req_valid = '0; req_idx = '0; req_fx = '0; req_fy = '0;
        rand_valid = 1'b0; obs_grants = 0;
        foreach (tb_buf[i]) tb_buf[i] = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2 check_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single lane, reverse index order
        for (int i = 3; i >= 0; i--) lq0.push_back(mk(i, 16'h0011 * i, 16'h1000 + i));
        drive_lanes();
        start_frame();
        wr_seen.delete();
        wait_phase(P_STREAM, 40);
        check("single_wr_count", wr_seen.size(), 4);
        repeat (3) cycle();
        finish_frame();

        // Round-robin: both lanes valid continuously
        lq0.push_back(mk(0, 16'h0100, 16'h0200));
        lq0.push_back(mk(1, 16'h0101, 16'h0201));
        lq1.push_back(mk(2, 16'h0102, 16'h0202));
        lq1.push_back(mk(3, 16'h0103, 16'h0203));
        drive_lanes();
        start_frame();
        wr_seen.delete();
        wait_phase(P_STREAM, 40);
        exp_rr = '{0, 2, 1, 3};
        check("rr_count", wr_seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_seq%0d", i), (wr_seen.size() > i) ? wr_seen[i] : -1, exp_rr[i]);
        end
        finish_frame();

        // Duplicate index: 1,1,0,2,3
        lq0.push_back(mk(1, 16'h0aa1, 16'h0bb1));
        lq0.push_back(mk(1, 16'h0aa9, 16'h0bb9));
        lq0.push_back(mk(0, 16'h0aa0, 16'h0bb0));
        lq0.push_back(mk(2, 16'h0aa2, 16'h0bb2));
        lq0.push_back(mk(3, 16'h0aa3, 16'h0bb3));
        drive_lanes();
        start_frame();
        wr_seen.delete();
        obs_grants = 0;
        wait_phase(P_STREAM, 40);
        check("dup_grants", obs_grants, 5);
        check("dup_wr_count", wr_seen.size(), 4);
        check("dup_flag", dup_err, 1);
        check("dup_buf1", tb_buf[1], 16'h0aa1);
        finish_frame();

        // Out-of-order completion (last write idx 0), then ABORT in STREAM
        // with a simultaneous START
        lq0.push_back(mk(1, 16'h1111, 16'h2221));
        lq0.push_back(mk(2, 16'h1112, 16'h2222));
        lq0.push_back(mk(3, 16'h1113, 16'h2223));
        lq0.push_back(mk(0, 16'hbeef, 16'h2220));
        drive_lanes();
        start_frame();
        wait_phase(P_STREAM, 40);
        check("ooo_frame_valid", frame_valid, 1);
        check("ooo_buf0", tb_buf[0], 16'hbeef);
        cycle();
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        repeat (2) cycle();

        // Back-to-back: START held across FIN
        for (int i = 0; i < 4; i++) lq0.push_back(mk(i, 16'h3000 + i, 16'h4000 + i));
        drive_lanes();
        start_frame();
        wait_phase(P_STREAM, 40);
        start = 1'b1;
        buf_done = 1'b1;
        cycle();
        buf_done = 1'b0;
        repeat (2) cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) lq1.push_back(mk(i, 16'h5000 + i, 16'h6000 + i));
        drive_lanes();
        wait_phase(P_STREAM, 40);
        check("b2b_buf3", tb_buf[3], 16'h5003);
        finish_frame();

        // Asynchronous reset mid-FILL
        lq0.push_back(mk(0, 16'h7000, 16'h7100));
        lq0.push_back(mk(1, 16'h7001, 16'h7101));
        lq1.push_back(mk(2, 16'h7002, 16'h7102));
        lq1.push_back(mk(3, 16'h7003, 16'h7103));
        drive_lanes();
        start_frame();
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1 check_zero("midfill");
        model_reset();
        lq0.delete();
        lq1.delete();
        drive_lanes();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) lq1.push_back(mk(3 - i, 16'h7700 + i, 16'h7800 + i));
        drive_lanes();
        start_frame();
        wait_phase(P_STREAM, 40);
        check("post_reset_buf0", tb_buf[0], 16'h7703);
        finish_frame();

        // Randomized frames: random lane assignment, valid gaps, duplicates,
        // BUF_DONE delay and occasional ABORT
        rand_valid = 1'b1;
        for (int f = 0; f < 10; f++) begin
            int n;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(2) == 0) begin
                    if ($urandom_range(1) == 0) lq0.push_back(mk($urandom_range(N - 1), $urandom, $urandom));
                    else                        lq1.push_back(mk($urandom_range(N - 1), $urandom, $urandom));
                end
                if ($urandom_range(1) == 0) lq0.push_back(mk(i, $urandom, $urandom));
                else                        lq1.push_back(mk(i, $urandom, $urandom));
            end
            drive_lanes();
            start_frame();
            n = 0;
            while (m_phase != P_IDLE && n < 300) begin
                buf_done = (m_phase == P_STREAM) && ($urandom_range(3) == 0);
                abort    = (f % 3 == 2) && ($urandom_range(15) == 0);
                cycle();
                n++;
            end
            abort    = 1'b0;
            buf_done = 1'b0;
            if (m_phase != P_IDLE) check("rand_frame_timeout", m_phase, P_IDLE);
            lq0.delete();
            lq1.delete();
            drive_lanes();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
